// File: rtl/uart_tx_pkg.sv
// Shared FSM encoding, output bit-select codes and width helper for the UART transmit serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;

  typedef enum logic [1:0] {
    SEL_START  = 2'd0,
    SEL_STOP   = 2'd1,
    SEL_DATA   = 2'd2,
    SEL_PARITY = 2'd3
  } bitSel_e;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Widths never collapse to zero, so small parameter values still get a real counter.
  function automatic int safeClog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Counts baud_tick strobes and pulses bitEnd_o on the OVERSAMPLE-th tick of each bit period.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  input  logic tick_i,
  output logic bitEnd_o
);

  localparam int CNT_W = safeClog2(OVERSAMPLE);

  logic [CNT_W-1:0] tickCnt_q, tickCnt_d;

  // A tick arriving together with clear is dropped, so every bit spans OVERSAMPLE fresh ticks.
  assign bitEnd_o = enable_i && !clear_i && tick_i && (tickCnt_q == CNT_W'(OVERSAMPLE - 1));

  always_comb begin
    tickCnt_d = tickCnt_q;
    if (clear_i) begin
      tickCnt_d = '0;
    end else if (enable_i && tick_i) begin
      tickCnt_d = bitEnd_o ? '0 : tickCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start, LSB-first data, optional parity and 1/2 stop bits on a registered tx.
// Defining UART_TX_BREAK_EN adds a tx_break input that holds the idle line low.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = safeClog2(DATA_BITS);

  txState_e             state_q, state_d;
  logic [IDX_W-1:0]     bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 parityEn_q, parityEn_d;
  logic                 parityOdd_q, parityOdd_d;
  logic                 twoStop_q, twoStop_d;
  logic                 secondStop_q, secondStop_d;
  logic                 txLine_q, txLine_d;
  logic                 done_q, done_d;
  logic                 break_q, break_d;
  logic                 breakReq, accept, timerClr, bitEnd, parityBit;
  bitSel_e              bitSel;

`ifdef UART_TX_BREAK_EN
  assign breakReq = tx_break;
`else
  assign breakReq = 1'b0;
`endif

  assign tx_ready = (state_q == IDLE) && !breakReq && !break_q;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE);
  assign tx       = txLine_q;
  assign tx_done  = done_q;

  uart_tx_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .clear_i (timerClr),
    .enable_i(busy),
    .tick_i  (baud_tick),
    .bitEnd_o(bitEnd)
  );

  always_comb begin
    state_d      = state_q;
    bitIdx_d     = bitIdx_q;
    data_d       = data_q;
    parityEn_d   = parityEn_q;
    parityOdd_d  = parityOdd_q;
    twoStop_d    = twoStop_q;
    secondStop_d = secondStop_q;
    done_d       = 1'b0;
    timerClr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d       = tx_data;
          parityEn_d   = parity_en;
          parityOdd_d  = parity_odd;
          twoStop_d    = two_stop;
          secondStop_d = 1'b0;
          bitIdx_d     = '0;
          timerClr     = 1'b1;
          state_d      = START;
        end
      end
      START: begin
        if (bitEnd) begin
          bitIdx_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = parityEn_q ? PARITY : STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (twoStop_q && !secondStop_q) begin
            secondStop_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is registered from next-state values so tx changes on the same edge as the FSM.
  assign parityBit = parityOdd_d ? ~^data_d : ^data_d;
  assign break_d   = (state_d == IDLE) && breakReq;

  always_comb begin
    bitSel   = SEL_STOP;
    txLine_d = 1'b1;
    case (state_d)
      START:   bitSel = SEL_START;
      DATA:    bitSel = SEL_DATA;
      PARITY:  bitSel = SEL_PARITY;
      default: bitSel = SEL_STOP;
    endcase
    case (bitSel)
      SEL_START:  txLine_d = 1'b0;
      SEL_DATA:   txLine_d = data_d[bitIdx_d];
      SEL_PARITY: txLine_d = parityBit;
      default:    txLine_d = 1'b1;
    endcase
    if (break_d) begin
      txLine_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      bitIdx_q     <= '0;
      data_q       <= '0;
      parityEn_q   <= 1'b0;
      parityOdd_q  <= 1'b0;
      twoStop_q    <= 1'b0;
      secondStop_q <= 1'b0;
      txLine_q     <= 1'b1;
      done_q       <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitIdx_q     <= bitIdx_d;
      data_q       <= data_d;
      parityEn_q   <= parityEn_d;
      parityOdd_q  <= parityOdd_d;
      twoStop_q    <= twoStop_d;
      secondStop_q <= secondStop_d;
      txLine_q     <= txLine_d;
      done_q       <= done_d;
      break_q      <= break_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues hand-written line patterns, a monitor checks them tick by tick.
module tb_uart_tx_serializer;

  localparam int OVS     = 16;
  localparam int TIMEOUT = 3000;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       tx;
  logic       busy;
  logic       tx_done;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif

  int    checks = 0;
  int    errors = 0;
  int    doneCount = 0;
  int    expectedDone = 0;
  bit    tickEn = 1'b0;
  bit    monBusy = 1'b0;
  string expQ[$];

  uart_tx_serializer #(
    .DATA_BITS (8),
    .OVERSAMPLE(OVS)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .baud_tick (baud_tick),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .two_stop  (two_stop),
`ifdef UART_TX_BREAK_EN
    .tx_break  (tx_break),
`endif
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 PCLK = ~PCLK;

  // Baud strobe every third PCLK so tick phase drifts against frame starts.
  initial begin
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge PCLK);
      #1;
      div = (div == 2) ? 0 : div + 1;
      baud_tick = tickEn && (div == 0);
    end
  end

  always @(negedge PCLK) begin
    if (tx_done === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic waitMonTick(input bit checkNow, output bit aborted);
    int n;
    n = 0;
    aborted = 1'b0;
    if (checkNow && baud_tick === 1'b1) return;
    forever begin
      @(negedge PCLK);
      if (PRESETn !== 1'b1) begin
        aborted = 1'b1;
        return;
      end
      if (baud_tick === 1'b1) return;
      n++;
      if (n > TIMEOUT) begin
        checks++;
        errors++;
        $display("[TB] FAIL monitor tick timeout: waited %0d cycles, required a baud_tick", n);
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic monitorFrame(input string exp);
    bit   aborted, bitOk;
    logic expBit, badVal;
    for (int b = 0; b < exp.len(); b++) begin
      expBit = (exp[b] == "1");
      bitOk  = 1'b1;
      badVal = expBit;
      for (int t = 0; t < OVS; t++) begin
        waitMonTick((b == 0) && (t == 0), aborted);
        if (aborted) return;
        if (tx !== expBit) begin
          bitOk  = 1'b0;
          badVal = tx;
        end
      end
      checks++;
      if (!bitOk) begin
        errors++;
        $display("[TB] FAIL frame %s bit %0d: tx got %b, required %b", exp, b, badVal, expBit);
      end
    end
    @(negedge PCLK);
    if (PRESETn !== 1'b1) return;
    checkOutput("tx_done at frame end", tx_done, 1);
    checkOutput("busy at frame end", busy, 0);
    checkOutput("tx high after stop", tx, 1);
  endtask

  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESETn === 1'b1 && busy === 1'b1) begin
        monBusy = 1'b1;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected frame: busy got 1, required 0 with nothing queued");
          while (busy === 1'b1) @(negedge PCLK);
        end else begin
          monitorFrame(expQ.pop_front());
        end
        monBusy = 1'b0;
      end
    end
  end

  task automatic waitTicks(input int count);
    int seen, n;
    seen = 0;
    n = 0;
    while (seen < count) begin
      @(negedge PCLK);
      if (baud_tick === 1'b1) seen++;
      if (++n > TIMEOUT) begin
        checkOutput("tick wait timeout", seen, count);
        return;
      end
    end
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (tx_ready === 1'b1) return;
      if (++n > TIMEOUT) begin
        checkOutput("tx_ready wait timeout", tx_ready, 1);
        return;
      end
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (tx_done === 1'b1) return;
      if (++n > TIMEOUT) begin
        checkOutput("tx_done wait timeout", tx_done, 1);
        return;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic po,
                               input logic ts, input string line, input bit completes);
    expQ.push_back(line);
    if (completes) expectedDone++;
    @(posedge PCLK);
    #1;
    tx_data    = data;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    tx_valid   = 1'b1;
    waitReady();
    @(posedge PCLK);
    #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic idleHigh;
    int   n;
    PRESETn    = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break   = 1'b0;
`endif
    repeat (3) @(negedge PCLK);
    checkOutput("reset tx", tx, 1);
    checkOutput("reset tx_ready", tx_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset tx_done", tx_done, 0);

    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    tickEn  = 1'b1;
    idleHigh = 1'b1;
    repeat (20) begin
      @(negedge PCLK);
      idleHigh = idleHigh & tx & ~busy;
    end
    checkOutput("idle line stays high", idleHigh, 1);

    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, "0101001011", 1'b1);
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, "01110000011", 1'b1);

    waitTicks(5);
    tickEn = 1'b0;
    repeat (150) @(negedge PCLK);
    checkOutput("start bit held without ticks", tx, 0);
    checkOutput("busy held without ticks", busy, 1);
    tickEn = 1'b1;

    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, "011100000011", 1'b1);

    // Word held valid across a frame whose inputs change underneath it.
    expQ.push_back("0110000111");
    expQ.push_back("000011000011");
    expectedDone += 2;
    @(posedge PCLK);
    #1;
    tx_data    = 8'hC3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    tx_valid   = 1'b1;
    waitReady();
    @(posedge PCLK);
    #1;
    tx_data   = 8'h18;
    parity_en = 1'b1;
    two_stop  = 1'b1;
    @(negedge PCLK);
    checkOutput("busy after accept", busy, 1);
    checkOutput("tx_ready low while busy", tx_ready, 0);
    waitDone();
    checkOutput("tx_ready with tx_done", tx_ready, 1);
    checkOutput("tx high in gap", tx, 1);
    @(negedge PCLK);
    checkOutput("back-to-back start bit", tx, 0);
    checkOutput("back-to-back busy", busy, 1);
    @(posedge PCLK);
    #1;
    tx_valid = 1'b0;

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, "0000000001", 1'b0);
    waitTicks(72);
    @(posedge PCLK);
    #2;
    checkOutput("tx in data bit 3", tx, 0);
    PRESETn = 1'b0;
    #1;
    checkOutput("async reset tx", tx, 1);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset tx_ready", tx_ready, 1);
    checkOutput("async reset tx_done", tx_done, 0);
    repeat (2) @(negedge PCLK);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;

    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, "0010110101", 1'b1);

`ifdef UART_TX_BREAK_EN
    waitReady();
    @(posedge PCLK);
    #1;
    tx_break = 1'b1;
    @(negedge PCLK);
    checkOutput("break tx_ready", tx_ready, 0);
    @(negedge PCLK);
    checkOutput("break tx low", tx, 0);
    expQ.push_back("0001111001");
    expectedDone++;
    @(posedge PCLK);
    #1;
    tx_data    = 8'h3C;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    tx_valid   = 1'b1;
    repeat (10) @(negedge PCLK);
    checkOutput("no accept during break", busy, 0);
    checkOutput("tx held low during break", tx, 0);
    @(posedge PCLK);
    #1;
    tx_break = 1'b0;
    @(negedge PCLK);
    checkOutput("tx_ready right after release", tx_ready, 0);
    @(negedge PCLK);
    checkOutput("tx after release", tx, 1);
    checkOutput("tx_ready after release", tx_ready, 1);
    @(posedge PCLK);
    #1;
    tx_valid = 1'b0;
`endif

    n = 0;
    while (expQ.size() != 0 || monBusy || busy !== 1'b0) begin
      @(negedge PCLK);
      if (++n > TIMEOUT) begin
        checkOutput("drain timeout, frames left", expQ.size(), 0);
        break;
      end
    end
    repeat (4) @(negedge PCLK);
    checkOutput("tx_done pulse count", doneCount, expectedDone);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
